// File: rtl/mem_arb_pkg.sv
// Shared types for the inst/data memory request arbiter.
// Round-robin grant is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/mem_req_arbiter_pick.sv
// Combinational winner selection between inst and data requesters.
// MEM_ARB_RR_EN: tie goes to whoever was not granted last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last,
  output logic   any,
  output owner_t win
);

  assign any = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    win = INST;
    unique case (1'b1)
      (i_req & d_req): win = (last == DATA) ? INST : DATA;
      d_req:           win = DATA;
      default:         win = INST;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last;
  assign win = d_req ? DATA : INST;
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like master port between inst and data requests.
// MEM_ARB_RR_EN selects round-robin instead of fixed data priority.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  output logic              stall
);

  state_t            state;
  owner_t            own;
  owner_t            last;
  owner_t            win;
  logic              any;
  logic              acc;
  logic              done;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  mem_arb_pick u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .last  (last),
    .any   (any),
    .win   (win)
  );

  assign acc  = (state == REQ) & m_addr_ok;
  assign done = ((state == REQ) | (state == WAIT)) & m_data_ok;

  assign i_addr_ok = acc & (own == INST);
  assign d_addr_ok = acc & (own == DATA);
  assign i_data_ok = done & (own == INST);
  assign d_data_ok = done & (own == DATA);

  assign i_rdata = i_data_ok ? m_rdata : i_rdata_q;
  assign d_rdata = d_data_ok ? m_rdata : d_rdata_q;

  assign stall = (i_req & ~i_data_ok) | (d_req & ~d_data_ok);

`ifndef MEM_ARB_RR_EN
  assign last = DATA;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      own       <= INST;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_size    <= 2'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last      <= DATA;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state   <= REQ;
            own     <= win;
            m_req   <= 1'b1;
            m_wr    <= (win == DATA) ? d_wr    : i_wr;
            m_size  <= (win == DATA) ? d_size  : i_size;
            m_addr  <= (win == DATA) ? d_addr  : i_addr;
            m_wdata <= (win == DATA) ? d_wdata : i_wdata;
`ifdef MEM_ARB_RR_EN
            last    <= win;
`endif
          end
        end
        REQ: begin
          // hold the request until the slave takes it
          if (m_data_ok) begin
            state <= IDLE;
            m_req <= 1'b0;
          end else if (m_addr_ok) begin
            state <= WAIT;
            m_req <= 1'b0;
          end
        end
        WAIT: begin
          if (m_data_ok) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
      if (i_data_ok) i_rdata_q <= m_rdata;
      if (d_data_ok) d_rdata_q <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter with a simple downstream model.
// Build with +define+MEM_ARB_RR_EN to check the round-robin build.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wr;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata, i_rdata;
  logic        i_addr_ok, i_data_ok;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_addr_ok, d_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        own;
  } mreq_t;

  mreq_t       exp_m[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  always #5 clk = ~clk;

  mem_req_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_rdata(i_rdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .stall(stall)
  );

  function automatic logic [31:0] resp(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h3C08_BFAF : ~a;
  endfunction

  function automatic mreq_t mk(input logic w, input logic [1:0] s,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic o);
    mreq_t r;
    r.wr = w; r.size = s; r.addr = a; r.wdata = wd; r.own = o;
    return r;
  endfunction

  // downstream slave: takes every request, answers lat cycles later
  logic [3:0]  cnt;
  logic [31:0] cap;
  assign m_addr_ok = m_req;
  assign m_data_ok = (m_req && lat == 0) || (cnt == 4'd1);
  assign m_rdata   = m_data_ok ? resp((cnt != 0) ? cap : m_addr) : 32'h0;

  always @(posedge clk) begin
    if (rst) cnt <= 4'd0;
    else if (m_req && m_addr_ok && lat != 0) begin
      cnt <= lat[3:0];
      cap <= m_addr;
    end else if (cnt != 0) cnt <= cnt - 4'd1;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a transfer
  mreq_t       em;
  logic [31:0] er;
  always @(negedge clk) begin
    if (m_req && m_addr_ok) begin
      if (exp_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_m_req actual=%h required=none", m_addr);
      end else begin
        em = exp_m.pop_front();
        chk("m_addr", 64'(m_addr), 64'(em.addr));
        chk("m_wdata", 64'(m_wdata), 64'(em.wdata));
        chk("m_wr_size", 64'({m_wr, m_size}), 64'({em.wr, em.size}));
        chk("addr_ok_route", 64'({d_addr_ok, i_addr_ok}),
            em.own ? 64'd2 : 64'd1);
      end
    end
    if (i_data_ok) begin
      if (exp_i.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_i_data_ok actual=%h required=none", i_rdata);
      end else begin
        er = exp_i.pop_front();
        chk("i_rdata", 64'(i_rdata), 64'(er));
      end
    end
    if (d_data_ok) begin
      if (exp_d.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_d_data_ok actual=%h required=none", d_rdata);
      end else begin
        er = exp_d.pop_front();
        chk("d_rdata", 64'(d_rdata), 64'(er));
      end
    end
  end

  // caller is at posedge+1 of cycle 0; returns at posedge+1 after data_ok
  task automatic i_xfer(input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit drop, output int lo);
    i_req = 1'b1; i_wr = w; i_size = s; i_addr = a; i_wdata = wd;
    lo = 0;
    forever begin
      @(negedge clk);
      if (i_data_ok) break;
      if (lo > 200) begin
        checks++; errors++;
        $display("FAIL i_timeout actual=%0d required=<200", lo);
        break;
      end
      @(posedge clk); #1; lo++;
    end
    @(posedge clk); #1;
    if (drop) i_req = 1'b0;
  endtask

  task automatic d_xfer(input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit drop, output int lo);
    d_req = 1'b1; d_wr = w; d_size = s; d_addr = a; d_wdata = wd;
    lo = 0;
    forever begin
      @(negedge clk);
      if (d_data_ok) break;
      if (lo > 200) begin
        checks++; errors++;
        $display("FAIL d_timeout actual=%0d required=<200", lo);
        break;
      end
      @(posedge clk); #1; lo++;
    end
    @(posedge clk); #1;
    if (drop) d_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  int li, ld;
  initial begin
    rst = 1'b1;
    i_req = 1'b1; i_wr = 0; i_size = 0; i_addr = 0; i_wdata = 0;
    d_req = 1'b0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd1);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_wdata", 64'({m_wr, m_size, m_wdata}), 64'd0);
    chk("rst_oks", 64'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 64'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    i_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // single inst read
    lat = 2;
    exp_m.push_back(mk(1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 1'b0));
    exp_i.push_back(32'h3C08_BFAF);
    fork
      i_xfer(1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 1'b1, li);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_in_wait", 64'(stall), 64'd1);
      end
    join
    chk("inst_latency", 64'(li), 64'd3);
    @(negedge clk);
    chk("stall_after", 64'(stall), 64'd0);
    chk("i_rdata_hold", 64'(i_rdata), 64'h3C08_BFAF);

    // contention
    do_reset();
    lat = 1;
`ifdef MEM_ARB_RR_EN
    exp_m.push_back(mk(1'b0, 2'd2, 32'hBFC0_0004, 32'h0, 1'b0));
    exp_m.push_back(mk(1'b1, 2'd2, 32'h8000_1000, 32'h1234_5678, 1'b1));
`else
    exp_m.push_back(mk(1'b1, 2'd2, 32'h8000_1000, 32'h1234_5678, 1'b1));
    exp_m.push_back(mk(1'b0, 2'd2, 32'hBFC0_0004, 32'h0, 1'b0));
`endif
    exp_i.push_back(resp(32'hBFC0_0004));
    exp_d.push_back(resp(32'h8000_1000));
    fork
      i_xfer(1'b0, 2'd2, 32'hBFC0_0004, 32'h0, 1'b1, li);
      d_xfer(1'b1, 2'd2, 32'h8000_1000, 32'h1234_5678, 1'b1, ld);
    join

    // continuous requests from both sides
    do_reset();
    lat = 1;
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      exp_m.push_back(mk(1'b0, 2'd2, 32'h1000_0000 + 32'(k * 4), 32'h0, 1'b0));
      exp_m.push_back(mk(1'b0, 2'd2, 32'h2000_0000 + 32'(k * 4), 32'h0, 1'b1));
    end
`else
    for (int k = 0; k < 3; k++)
      exp_m.push_back(mk(1'b0, 2'd2, 32'h2000_0000 + 32'(k * 4), 32'h0, 1'b1));
    for (int k = 0; k < 3; k++)
      exp_m.push_back(mk(1'b0, 2'd2, 32'h1000_0000 + 32'(k * 4), 32'h0, 1'b0));
`endif
    for (int k = 0; k < 3; k++) begin
      exp_i.push_back(resp(32'h1000_0000 + 32'(k * 4)));
      exp_d.push_back(resp(32'h2000_0000 + 32'(k * 4)));
    end
    fork
      begin
        for (int k = 0; k < 3; k++)
          i_xfer(1'b0, 2'd2, 32'h1000_0000 + 32'(k * 4), 32'h0, k == 2, li);
      end
      begin
        for (int k = 0; k < 3; k++)
          d_xfer(1'b0, 2'd2, 32'h2000_0000 + 32'(k * 4), 32'h0, k == 2, ld);
      end
    join

    // addr_ok and data_ok in the same cycle
    do_reset();
    lat = 0;
    exp_m.push_back(mk(1'b0, 2'd1, 32'h3000_0000, 32'h0, 1'b1));
    exp_d.push_back(resp(32'h3000_0000));
    fork
      d_xfer(1'b0, 2'd1, 32'h3000_0000, 32'h0, 1'b1, ld);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("same_cycle_oks", 64'({d_addr_ok, d_data_ok}), 64'd3);
        @(negedge clk);
        chk("same_cycle_idle", 64'(m_req), 64'd0);
      end
    join
    chk("same_cycle_latency", 64'(ld), 64'd1);

    // reset while waiting for data
    do_reset();
    lat = 5;
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2;
    d_addr = 32'h4000_0000; d_wdata = 32'h0;
    exp_m.push_back(mk(1'b0, 2'd2, 32'h4000_0000, 32'h0, 1'b1));
    exp_m.push_back(mk(1'b0, 2'd2, 32'h4000_0000, 32'h0, 1'b1));
    exp_d.push_back(resp(32'h4000_0000));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_no_data_ok", 64'(d_data_ok), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 1;
    @(negedge clk);
    chk("rst_wait_idle", 64'({m_req, d_data_ok}), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wait_regrant", 64'(m_req), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wait_done", 64'(d_data_ok), 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0;

    // payload change while granted
    do_reset();
    lat = 2;
    exp_m.push_back(mk(1'b1, 2'd0, 32'h5000_0010, 32'hAABB_CCDD, 1'b1));
    exp_d.push_back(resp(32'h5000_0010));
    fork
      d_xfer(1'b1, 2'd0, 32'h5000_0010, 32'hAABB_CCDD, 1'b1, ld);
      begin
        @(posedge clk); #1;
        d_addr = 32'hDEAD_BEEC;
        d_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("stable_m_addr", 64'(m_addr), 64'h5000_0010);
      end
    join

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("exp_m_drained", 64'(exp_m.size()), 64'd0);
    chk("exp_i_drained", 64'(exp_i.size()), 64'd0);
    chk("exp_d_drained", 64'(exp_d.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
